stdp_synapse_bank: RTL
======================

// Module: stdp_synapse_bank
// PURPOSE
//  Parametrised STDP weight engine for CH presynaptic channels converging on one postsynaptic
//  izhikevich_core. Tracks per-channel spike ages in timesteps (one per apply) and the post age.
//  On each apply, scans channels sequentially and applies linear-window pair STDP.
//  Weights stay on-chip; the weighted input-current stage reads them in parallel.
// PARAMETERS
//  N       32          data width, signed fixed point
//  Q       16          fractional bits
//  CH      8           presynaptic channel count (>=1)
//  T_W     8           age counter width; must satisfy T_W <= N-Q-1
//  W_INIT  32'h8000    weight reset value (0.5 at Q=16)
// PORTS
//  clk            in   1          clock
//  rst            in   1          async reset, active-high
//  apply          in   1          timestep strobe, 1-cycle pulse
//  pre_spike      in   CH         presynaptic spikes for this timestep, sampled on accepted apply
//  post_spike     in   1          postsynaptic spike (is_spiking), sampled on accepted apply
//  m_ltp,b_ltp    in   N each     LTP window: dw+ = max(0, b_ltp - m_ltp*dt)
//  m_ltd,b_ltd    in   N each     LTD window: dw- = max(0, b_ltd - m_ltd*dt)
//  w_min,w_max    in   N each     weight bounds, w_min <= w_max
//  rd_sel         in   clog2(CH)  readback select
//  rd_weight      out  N          weight[rd_sel], combinational
//  weights_flat   out  CH*N       all weights; ch k at [k*N +: N]
//  busy           out  1          scan in progress
//  apply_dropped  out  1          sticky; set when apply arrives while busy
// BEHAVIOUR
//  Reset: weights=W_INIT; all ages=2^T_W-1; valid bits=0; busy=0; apply_dropped=0; FSM=IDLE.
//    Reset mid-scan aborts immediately. Partial updates are discarded by the reset values.
//  FSM IDLE -> SCAN -> COMMIT -> IDLE.
//   IDLE: apply=1 latches pre_spike/post_spike. Increments every age, saturating at 2^T_W-1.
//     Goes to SCAN with idx=0.
//   SCAN: one channel per cycle, idx 0..CH-1, then COMMIT. busy=1 throughout SCAN and COMMIT.
//   COMMIT: for latched spiking channels, age=0 and valid=1; same for post if post latched.
//     Returns to IDLE.
//  Latency: apply in cycle 0; busy=1 cycles 1..CH+1; weights final and busy=0 in cycle CH+2.
//    Next apply is accepted in cycle CH+2.
//  apply while busy: ignored (no latch, no age change); apply_dropped<=1 until rst.
//  Per channel k in SCAN:
//   LTP term: only if post latched and pre_valid[k]; dt = pre_age[k] << Q.
//   LTD term: only if pre[k] latched and post_valid; dt = post_age << Q.
//   Coincident pre+post in one step uses each side's previous age; dt is never 0.
//   m*dt: signed N x N -> 2N, take bits [N+Q-1:Q], saturate to N-bit signed range.
//     Negative (b - m*dt) -> 0.
//   w_new = clamp(w + ltp - ltd, w_min, w_max). Intermediate sum is N+1 bits, no wrap.
//   Saturated age (2^T_W-1) is still used as a valid dt; windows normally zero it.
//  Weights change only on the SCAN cycle of their own channel.
// CONFIGURATION
//  STDP_SOFT_BOUND_EN defined:
//    ltp is multiplied by (w_max - w) and ltd by (w - w_min), Q-format.
//    Adds one multiplier pair; scan timing unchanged; clamp retained.
//  Undefined: additive hard-bound rule as above.
// TESTING  (N=32, Q=16, CH=4, W_INIT=0x8000, m=0x2000 (0.125), b=0x8000 (0.5),
//           w_min=0, w_max=0x10000)
//  1. LTP: pre[0] at step0; idle apply at step1; post at step2 -> dt=2.0, dw=+0.25.
//     weight[0]=0xC000 at cycle CH+2 after the step-2 apply; others 0x8000.
//  2. LTD: post at step0; pre[1] at step3 -> dt=3.0, dw=-0.125. weight[1]=0x6000.
//  3. Window cutoff: pre[2] at step0, post at step5 -> b - m*dt = -0.125 -> 0.
//     weight[2] stays 0x8000.
//  4. Bound: w_max=0x9000, repeat scenario 1 -> weight[0]=0x9000.
//     w_min=0x7000 with scenario 2 -> weight[1]=0x7000.
//  5. Handshake: apply at cycle 0 and again at cycle 2 (CH=4).
//     Second apply is ignored: apply_dropped=1, ages advance once, busy=0 at cycle 6.
//  6. Reset mid-scan at cycle 3 -> busy=0 and all weights 0x8000 at once.
//     Next apply + post changes no weight (no valid pre).
//     With STDP_SOFT_BOUND_EN, scenario 1 gives 0x8000 + 0.25*0.5 = 0xA000.

Source files
------------

// File: rtl/stdp_synapse_bank_if.sv
// stdp_synapse_bank_if: timestep strobe, STDP window parameters and weight readback for stdp_synapse_bank
interface stdp_synapse_bank_if #(
  parameter int N = 32,
  parameter int CH = 8,
  parameter int RW = (CH > 1) ? $clog2(CH) : 1
);
  logic apply;
  logic [CH-1:0] pre_spike;
  logic post_spike;
  logic signed [N-1:0] m_ltp;
  logic signed [N-1:0] b_ltp;
  logic signed [N-1:0] m_ltd;
  logic signed [N-1:0] b_ltd;
  logic signed [N-1:0] w_min;
  logic signed [N-1:0] w_max;
  logic [RW-1:0] rd_sel;
  logic signed [N-1:0] rd_weight;
  logic [CH*N-1:0] weights_flat;
  logic busy;
  logic apply_dropped;
  modport master (
    output apply, pre_spike, post_spike, m_ltp, b_ltp, m_ltd, b_ltd, w_min, w_max, rd_sel,
    input rd_weight, weights_flat, busy, apply_dropped
  );
  modport slave (
    input apply, pre_spike, post_spike, m_ltp, b_ltp, m_ltd, b_ltd, w_min, w_max, rd_sel,
    output rd_weight, weights_flat, busy, apply_dropped
  );
endinterface

// File: rtl/stdp_synapse_bank.sv
// stdp_synapse_bank: pair-STDP weight engine scanning CH presynaptic channels once per timestep.
// Define STDP_SOFT_BOUND_EN to scale ltp by (w_max - w) and ltd by (w - w_min).
module stdp_synapse_bank #(
  parameter int N = 32,
  parameter int Q = 16,
  parameter int CH = 8,
  parameter int T_W = 8,
  parameter logic [N-1:0] W_INIT = 'h8000
) (
  input logic clk,
  input logic rst,
  stdp_synapse_bank_if.slave bus
);
  localparam int RW = (CH > 1) ? $clog2(CH) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  state_t state_q, state_d;
  logic [RW-1:0] idx_q, idx_d;
  logic [CH-1:0] pre_lat_q, pre_lat_d, pre_valid_q, pre_valid_d;
  logic post_lat_q, post_lat_d, post_valid_q, post_valid_d;
  logic [T_W-1:0] pre_age_q [CH];
  logic [T_W-1:0] pre_age_d [CH];
  logic [T_W-1:0] post_age_q, post_age_d;
  logic signed [N-1:0] w_q [CH];
  logic signed [N-1:0] w_d [CH];
  logic dropped_q, dropped_d;
  logic signed [N-1:0] sel_w, w_new;
  logic signed [N:0] ltp, ltd;
  logic signed [N+1:0] ltp_e, ltd_e, sum, lo, hi;
  // max(0, b - m*dt) with dt = age in Q format; product saturated to N bits
  function automatic logic signed [N:0] window(input logic signed [N-1:0] m, b,
                                               input logic [T_W-1:0] age);
    logic signed [N-1:0] dt;
    logic signed [2*N-1:0] p;
    logic signed [N-1:0] ps;
    logic signed [N:0] d;
    dt = $signed({{(N-T_W){1'b0}}, age} << Q);
    p = m * dt;
    ps = (&p[2*N-1:N+Q-1] || ~|p[2*N-1:N+Q-1]) ? p[N+Q-1:Q]
       : (p[2*N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}});
    d = {b[N-1], b} - {ps[N-1], ps};
    return d[N] ? '0 : d;
  endfunction
  always_comb begin
    sel_w = w_q[idx_q];
    ltp = (post_lat_q && pre_valid_q[idx_q]) ? window(bus.m_ltp, bus.b_ltp, pre_age_q[idx_q]) : '0;
    ltd = (pre_lat_q[idx_q] && post_valid_q) ? window(bus.m_ltd, bus.b_ltd, post_age_q) : '0;
`ifdef STDP_SOFT_BOUND_EN
    ltp_e = (N+2)'((ltp * ({bus.w_max[N-1], bus.w_max} - {sel_w[N-1], sel_w})) >>> Q);
    ltd_e = (N+2)'((ltd * ({sel_w[N-1], sel_w} - {bus.w_min[N-1], bus.w_min})) >>> Q);
`else
    ltp_e = {ltp[N], ltp};
    ltd_e = {ltd[N], ltd};
`endif
    sum = {{2{sel_w[N-1]}}, sel_w} + ltp_e - ltd_e;
    lo = {{2{bus.w_min[N-1]}}, bus.w_min};
    hi = {{2{bus.w_max[N-1]}}, bus.w_max};
    w_new = (sum < lo) ? bus.w_min : (sum > hi) ? bus.w_max : sum[N-1:0];
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    pre_lat_d = pre_lat_q;
    post_lat_d = post_lat_q;
    pre_valid_d = pre_valid_q;
    post_valid_d = post_valid_q;
    pre_age_d = pre_age_q;
    post_age_d = post_age_q;
    w_d = w_q;
    dropped_d = dropped_q | (bus.apply && state_q != IDLE);
    case (state_q)
      IDLE: if (bus.apply) begin
        pre_lat_d = bus.pre_spike;
        post_lat_d = bus.post_spike;
        for (int k = 0; k < CH; k++)
          pre_age_d[k] = &pre_age_q[k] ? pre_age_q[k] : pre_age_q[k] + 1'b1;
        post_age_d = &post_age_q ? post_age_q : post_age_q + 1'b1;
        idx_d = '0;
        state_d = SCAN;
      end
      SCAN: begin
        w_d[idx_q] = w_new;
        idx_d = idx_q + 1'b1;
        state_d = (idx_q == RW'(CH-1)) ? COMMIT : SCAN;
      end
      COMMIT: begin
        for (int k = 0; k < CH; k++)
          if (pre_lat_q[k]) pre_age_d[k] = '0;
        pre_valid_d = pre_valid_q | pre_lat_q;
        post_age_d = post_lat_q ? '0 : post_age_q;
        post_valid_d = post_valid_q | post_lat_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      pre_lat_q <= '0;
      post_lat_q <= 1'b0;
      pre_valid_q <= '0;
      post_valid_q <= 1'b0;
      post_age_q <= '1;
      dropped_q <= 1'b0;
      for (int k = 0; k < CH; k++) begin
        pre_age_q[k] <= '1;
        w_q[k] <= W_INIT;
      end
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      pre_lat_q <= pre_lat_d;
      post_lat_q <= post_lat_d;
      pre_valid_q <= pre_valid_d;
      post_valid_q <= post_valid_d;
      post_age_q <= post_age_d;
      dropped_q <= dropped_d;
      pre_age_q <= pre_age_d;
      w_q <= w_d;
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.apply_dropped = dropped_q;
  assign bus.rd_weight = w_q[bus.rd_sel];
  for (genvar g = 0; g < CH; g++) begin : g_flat
    assign bus.weights_flat[g*N +: N] = w_q[g];
  end
endmodule
